// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - data-memory request/response signal bundle
// Requester drives the master side; the responder implements the slave side.
interface data_mem_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_busy;
  logic        mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    input  mem_rdata, mem_ack, mem_busy, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    output mem_rdata, mem_ack, mem_busy, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data-memory responder over a word RAM
// Optional DMEM_BOUNDS_CHECK_EN: addresses above the array are dropped and flagged on mem_err.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e          state_q, state_d;
  logic [3:0]      count_q, count_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            oob_q, oob_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     ram [DEPTH_WORDS];

  logic            cur_we;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic [3:0]      cur_be;
  logic            cur_oob;
  logic            in_oob;
  logic            commit;
  logic            ram_wr;
  logic            unused_addr_bits;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign in_oob           = |bus.mem_addr[31:AW+2];
  assign unused_addr_bits = ^bus.mem_addr[1:0];
`else
  assign in_oob           = 1'b0;
  assign unused_addr_bits = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    oob_d     = oob_q;
    rdata_d   = rdata_q;
    commit    = 1'b0;
    // With zero wait states the commit happens on the capture edge, so use live inputs.
    cur_we    = we_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    cur_oob   = oob_q;

    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          idx_d     = bus.mem_addr[AW+1:2];
          we_d      = bus.mem_we;
          wdata_d   = bus.mem_wdata;
          be_d      = bus.mem_byte_en;
          oob_d     = in_oob;
          count_d   = WAIT_INIT;
          cur_we    = bus.mem_we;
          cur_idx   = bus.mem_addr[AW+1:2];
          cur_wdata = bus.mem_wdata;
          cur_be    = bus.mem_byte_en;
          cur_oob   = in_oob;
          if (WAIT_INIT == 4'd0) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = ACK;
          commit  = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (commit && !cur_we) begin
      rdata_d = cur_oob ? 32'h0 : ram[cur_idx];
    end
    ram_wr = commit && cur_we && !cur_oob;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      oob_q   <= oob_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; a reset on the commit edge discards the pending write.
  always_ff @(posedge clk) begin
    if (ram_wr && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) begin
          ram[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_ack   = (state_q == ACK);
  assign bus.mem_busy  = (state_q != IDLE);
  assign bus.mem_rdata = rdata_q;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign bus.mem_err   = (state_q == ACK) && oob_q;
`else
  assign bus.mem_err   = 1'b0;
`endif
endmodule
